// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, debug state codes and bit-period helper.
// The helper is shared with uart_tx so both ends derive the same bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } uart_rx_state_t;

    localparam logic [1:0] STATE_BITS_IDLE   = 2'b00;
    localparam logic [1:0] STATE_BITS_START  = 2'b01;
    localparam logic [1:0] STATE_BITS_DATA   = 2'b11;
    localparam logic [1:0] STATE_BITS_STOP   = 2'b10;
    localparam logic [1:0] STATE_BITS_PARITY = 2'b11;

    function automatic int clocks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage synchroniser for an asynchronous input; rst_val sets the value all stages take in reset.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= {STAGES{rst_val}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing and start-glitch rejection.
// Optional even-parity bit and parity_err output when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_RATE      = 50000000,
    parameter int BAUD_RATE     = 115200,
    parameter int BITS_PER_WORD = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy,
    output logic [1:0] state_bits
);

    localparam int CPB   = clocks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int HALF  = CPB / 2 - 1;
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = $clog2(BITS_PER_WORD) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS_PER_WORD - 1);

    logic rx_s;

    uart_rx_sync #(.STAGES(2)) u_sync (
        .clk     (clk),
        .rstn    (rstn),
        .rst_val (1'b1),
        .d       (rx),
        .q       (rx_s)
    );

    uart_rx_state_t   state, state_next;
    logic [CNT_W-1:0] clk_count, count_next;
    logic [IDX_W-1:0] bit_index, index_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       data_next;
    logic             valid_next, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic             parity_bit, parity_next, perr_next, perr_calc;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            clk_count  <= '0;
            bit_index  <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            clk_count  <= count_next;
            bit_index  <= index_next;
            shift_reg  <= shift_next;
            data_out   <= data_next;
            data_valid <= valid_next;
            frame_err  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            parity_bit <= parity_next;
            parity_err <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        count_next = clk_count;
        index_next = bit_index;
        shift_next = shift_reg;
        data_next  = data_out;
        valid_next = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_next = parity_bit;
        perr_next   = 1'b0;
        perr_calc   = (^shift_reg) ^ parity_bit;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    count_next = '0;
                    index_next = '0;
                    shift_next = '0;
                end
            end
            START: begin
                if (clk_count == CNT_HALF) begin
                    count_next = '0;
                    // A start bit that is high again at its centre was a glitch.
                    state_next = rx_s ? IDLE : DATA;
                end else begin
                    count_next = clk_count + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_count == CNT_LAST) begin
                    count_next = '0;
                    shift_next = shift_reg | (8'(rx_s) << bit_index);
                    index_next = bit_index + IDX_W'(1);
                    if (bit_index == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end else begin
                    count_next = clk_count + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_count == CNT_LAST) begin
                    count_next  = '0;
                    parity_next = rx_s;
                    state_next  = STOP;
                end else begin
                    count_next = clk_count + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop-bit so a following start edge half a bit later is caught.
                if (clk_count == CNT_LAST) begin
                    count_next = '0;
                    state_next = IDLE;
                    ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                    perr_next  = perr_calc;
                    if (rx_s && !perr_calc) begin
`else
                    if (rx_s) begin
`endif
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                    end
                end else begin
                    count_next = clk_count + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        state_bits = STATE_BITS_IDLE;
        case (state)
            IDLE:    state_bits = STATE_BITS_IDLE;
            START:   state_bits = STATE_BITS_START;
            DATA:    state_bits = STATE_BITS_DATA;
            STOP:    state_bits = STATE_BITS_STOP;
            PARITY:  state_bits = STATE_BITS_PARITY;
            default: state_bits = STATE_BITS_IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames queue expected events, a monitor checks each pulse.
module tb_uart_rx;

    localparam int CPB = 50000000 / 115200;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;
    localparam int K_BOTH  = 3;
    localparam int K_BAD   = 9;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       perr_w;
    logic       busy;
    logic [1:0] state_bits;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    uart_rx dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (perr_w),
`endif
        .busy       (busy),
        .state_bits (state_bits)
    );

`ifndef UART_RX_PARITY_EN
    assign perr_w = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_bit;
        repeat (CPB) @(negedge clk);
`endif
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rstn && (data_valid || frame_err || perr_w)) begin
            int obs;
            exp_t e;
            if (data_valid && !frame_err && !perr_w)      obs = K_VALID;
            else if (frame_err && !data_valid && !perr_w) obs = K_FERR;
            else if (perr_w && !data_valid && !frame_err) obs = K_PERR;
            else if (perr_w && frame_err && !data_valid)  obs = K_BOTH;
            else                                          obs = K_BAD;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind=%0d data=%02h, required no pulse", obs, data_out);
            end else begin
                e = sb.pop_front();
                check("event_kind", obs, e.kind);
                check("event_data", {24'd0, data_out}, {24'd0, e.data});
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_data_out", {24'd0, data_out}, 32'h0);
        check("reset_data_valid", {31'd0, data_valid}, 32'h0);
        check("reset_frame_err", {31'd0, frame_err}, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'h0);
        check("reset_state_bits", {30'd0, state_bits}, 32'h0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        // single frame with state tracking along the way
        push(K_VALID, 8'h55);
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                repeat (100) @(negedge clk);
                check("t1_busy_start", {31'd0, busy}, 32'h1);
                check("t1_state_start", {30'd0, state_bits}, 32'h1);
                repeat (CPB) @(negedge clk);
                check("t1_state_data", {30'd0, state_bits}, 32'h3);
                repeat (8 * CPB) @(negedge clk);
`ifdef UART_RX_PARITY_EN
                check("t1_state_parity", {30'd0, state_bits}, 32'h3);
`else
                check("t1_state_stop", {30'd0, state_bits}, 32'h2);
`endif
            end
        join
        repeat (20) @(negedge clk);
        check("t1_busy_after", {31'd0, busy}, 32'h0);
        check("t1_state_after", {30'd0, state_bits}, 32'h0);

        // back-to-back frames with no idle gap
        push(K_VALID, 8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        push(K_VALID, 8'h00);
        send_frame(8'h00, 1'b1, 1'b0);
        push(K_VALID, 8'hFF);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (20) @(negedge clk);

        // short low glitch must not start a frame
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("t3_state_idle", {30'd0, state_bits}, 32'h0);
        check("t3_busy", {31'd0, busy}, 32'h0);
        check("t3_data_kept", {24'd0, data_out}, 32'hFF);

        // bad stop bit: frame error, previous word retained
        push(K_FERR, 8'hFF);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (CPB) @(negedge clk);
        check("t4_data_kept", {24'd0, data_out}, 32'hFF);

        // reset in the middle of data bit 4
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                repeat (5 * CPB + 200) @(negedge clk);
                rstn = 1'b0;
                repeat (3) @(negedge clk);
                check("t5_reset_data", {24'd0, data_out}, 32'h0);
                check("t5_reset_busy", {31'd0, busy}, 32'h0);
                check("t5_reset_state", {30'd0, state_bits}, 32'h0);
            end
        join
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        push(K_VALID, 8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("t5_data_final", {24'd0, data_out}, 32'h81);

`ifdef UART_RX_PARITY_EN
        push(K_VALID, 8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        push(K_PERR, 8'h07);
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
`endif

        repeat (50) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
